// File: rtl/uart_transaction_sequencer.sv
// Runs one request/response exchange over a shared byte UART: sends a 5-byte command frame,
// collects a 4-byte response, validates it and retries on timeout or checksum failure.
module uart_transaction_sequencer #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         MAX_RETRY      = 3,
    parameter logic [7:0] HDR_CMD        = 8'hAA,
    parameter logic [7:0] HDR_RSP        = 8'h55
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic [7:0]  txdata,
    output logic        wr_en,
    input  logic        tx_busy,
    input  logic [7:0]  rxdata,
    input  logic        rdy,
    output logic        rdy_clr,
    output logic [3:0]  state
);
    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        SEND          = 4'd1,
        WAIT_TX       = 4'd2,
        WAIT_HDR      = 4'd3,
        WAIT_STATUS   = 4'd4,
        WAIT_DATA     = 4'd5,
        WAIT_CHECKSUM = 4'd6,
        CHECK         = 4'd7,
        DONE          = 4'd8
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t          st;
    logic [2:0]      idx;
    logic [RW-1:0]   retry;
    logic [TW-1:0]   tocnt;
    logic            tx_first;
    logic [1:0]      err;
    logic [7:0]      cmd, arg, opd, txsum;
    logic [7:0]      status, data, rxsum;
    logic            rx_state, accept, timeout;
    logic            unused_bits;

    assign state       = st;
    assign unused_bits = ^{dataa[31:16], datab[31:8]};
    assign rx_state    = (st == WAIT_HDR) || (st == WAIT_STATUS) ||
                         (st == WAIT_DATA) || (st == WAIT_CHECKSUM);
    // rdy stays high until our acknowledge lands, so never re-accept while rdy_clr is out
    assign accept      = rx_state && rdy && !rdy_clr;
    assign timeout     = rx_state && !accept && (tocnt == TO_LAST);

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [7:0] c,
                                              input logic [7:0] a, input logic [7:0] o,
                                              input logic [7:0] s);
        case (i)
            3'd0:    frame_byte = HDR_CMD;
            3'd1:    frame_byte = c;
            3'd2:    frame_byte = a;
            3'd3:    frame_byte = o;
            default: frame_byte = s;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (st == IDLE && start) begin
            cmd   <= dataa[7:0];
            arg   <= dataa[15:8];
            opd   <= datab[7:0];
            txsum <= dataa[7:0] + dataa[15:8] + datab[7:0];
        end
        if (accept) begin
            case (st)
                WAIT_STATUS:   status <= rxdata;
                WAIT_DATA:     data   <= rxdata;
                WAIT_CHECKSUM: rxsum  <= rxdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            idx      <= '0;
            retry    <= '0;
            tocnt    <= '0;
            tx_first <= 1'b0;
            err      <= 2'b00;
            result   <= '0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            rdy_clr  <= 1'b0;
            txdata   <= '0;
        end else begin
            wr_en   <= 1'b0;
            done    <= 1'b0;
            rdy_clr <= accept;
            if (rx_state)
                tocnt <= accept ? '0 : tocnt + 1'b1;

            case (st)
                IDLE: begin
                    if (start) begin
                        retry <= '0;
                        idx   <= '0;
                        st    <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        txdata   <= frame_byte(idx, cmd, arg, opd, txsum);
                        wr_en    <= 1'b1;
                        tx_first <= 1'b1;
                        st       <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    // transmitter raises busy one clock after the strobe
                    if (tx_first) begin
                        tx_first <= 1'b0;
                    end else if (!tx_busy) begin
                        if (idx != 3'd4) begin
                            idx <= idx + 3'd1;
                            st  <= SEND;
                        end else begin
                            tocnt <= '0;
                            st    <= WAIT_HDR;
                        end
                    end
                end
                WAIT_HDR:      if (accept && rxdata == HDR_RSP) st <= WAIT_STATUS;
                WAIT_STATUS:   if (accept) st <= WAIT_DATA;
                WAIT_DATA:     if (accept) st <= WAIT_CHECKSUM;
                WAIT_CHECKSUM: if (accept) st <= CHECK;
                CHECK: begin
                    if (rxsum == status + data) begin
                        err <= 2'b00;
                        st  <= DONE;
                    end else if (retry < RETRY_LIM) begin
                        retry <= retry + 1'b1;
                        idx   <= '0;
                        st    <= SEND;
                    end else begin
                        err <= 2'b10;
                        st  <= DONE;
                    end
                end
                DONE: begin
                    result <= {14'b0, err, status, data};
                    done   <= 1'b1;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase

            // an accepted byte always beats expiry because timeout excludes accept cycles
            if (timeout) begin
                if (retry < RETRY_LIM) begin
                    retry <= retry + 1'b1;
                    idx   <= '0;
                    st    <= SEND;
                end else begin
                    err <= 2'b01;
                    st  <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_transaction_sequencer.sv
// Scoreboard bench for uart_transaction_sequencer: randomized transactions against a
// frame-level reference model, plus directed retry, timeout, garbage and reset scenarios.
module tb_uart_transaction_sequencer;
    localparam int         TO = 100;
    localparam int         MR = 3;
    localparam logic [7:0] HC = 8'hAA;
    localparam logic [7:0] HR = 8'h55;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, tx_busy = 1'b0, rdy = 1'b0;
    logic [31:0] dataa = '0, datab = '0;
    logic [7:0]  rxdata = '0;
    logic [31:0] result;
    logic        done, wr_en, rdy_clr;
    logic [7:0]  txdata;
    logic [3:0]  state;

    int checks = 0, passed = 0;
    int tx_bytes = 0, ndone = 0, rc_cnt = 0, busy_left = 0, cur_len = 0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_res[$];
    int          exp_rc[$];
    logic [7:0]  pbytes[$];
    int          plen[$];
    logic [7:0]  last_st = '0, last_dt = '0;

    uart_transaction_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR),
                                 .HDR_CMD(HC), .HDR_RSP(HR)) dut (
        .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
        .result(result), .done(done), .txdata(txdata), .wr_en(wr_en), .tx_busy(tx_busy),
        .rxdata(rxdata), .rdy(rdy), .rdy_clr(rdy_clr), .state(state)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endfunction

    function automatic void fail_now(input string nm);
        checks++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endfunction

    // Reference model: walks the planned responses attempt by attempt.
    function automatic logic [31:0] model(output int att);
        int p = 0;
        logic [1:0] err = 2'b01;
        att = 0;
        for (int k = 0; k < plen.size() && k <= MR; k++) begin
            int n, h;
            n = plen[k];
            h = -1;
            att++;
            for (int i = 0; i < n; i++)
                if (h < 0 && pbytes[p+i] == HR) h = i;
            if (h >= 0 && h + 1 < n) last_st = pbytes[p+h+1];
            if (h >= 0 && h + 2 < n) last_dt = pbytes[p+h+2];
            if (h >= 0 && h + 3 < n) begin
                logic [7:0] sm;
                sm = last_st + last_dt;
                err = (pbytes[p+h+3] == sm) ? 2'b00 : 2'b10;
            end else begin
                err = 2'b01;
            end
            p += n;
            if (err == 2'b00) break;
        end
        return {14'b0, err, last_st, last_dt};
    endfunction

    task automatic clear_plan();
        pbytes.delete();
        plen.delete();
        cur_len = 0;
    endtask

    task automatic push_b(input logic [7:0] b);
        pbytes.push_back(b);
        cur_len++;
    endtask

    task automatic end_att();
        plen.push_back(cur_len);
        cur_len = 0;
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
        push_b(a); push_b(b); push_b(c); push_b(d);
        end_att();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rdy = 1'b1;
        rxdata = b;
        while (!rdy_clr && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_clr) fail_now("ack_wait");
        @(negedge clk);
        rdy = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_bytes < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx_bytes < target) fail_now("frame_wait");
    endtask

    task automatic pulse_start(input logic [31:0] da, input logic [31:0] db);
        @(negedge clk);
        dataa = da;
        datab = db;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom;
        datab = $urandom;
    endtask

    task automatic push_frames(input logic [7:0] c, input logic [7:0] a, input logic [7:0] o,
                               input int att);
        logic [7:0] s;
        s = c + a + o;
        for (int k = 0; k < att; k++) begin
            exp_tx.push_back(HC); exp_tx.push_back(c); exp_tx.push_back(a);
            exp_tx.push_back(o);  exp_tx.push_back(s);
        end
    endtask

    task automatic run_txn(input logic [31:0] da, input logic [31:0] db);
        logic [31:0] res;
        int att, base, d0, p, n;
        res = model(att);
        push_frames(da[7:0], da[15:8], db[7:0], att);
        exp_res.push_back(res);
        exp_rc.push_back(pbytes.size());
        base = tx_bytes;
        d0 = ndone;
        rc_cnt = 0;
        pulse_start(da, db);
        p = 0;
        for (int k = 0; k < plen.size(); k++) begin
            wait_tx(base + 5 * (k + 1));
            if (k == 0) pulse_start($urandom, $urandom);
            for (int i = 0; i < plen[k]; i++) send_byte(pbytes[p+i]);
            p += plen[k];
        end
        n = 0;
        while (ndone == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (ndone == d0) fail_now("done_wait");
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    // Transmitter model and byte checker
    initial begin
        forever begin
            @(negedge clk);
            if (wr_en) begin
                chk("tx_busy_at_write", {31'b0, tx_busy}, 32'd0);
                if (exp_tx.size() == 0) fail_now("unexpected_write");
                else chk("txdata", {24'b0, txdata}, {24'b0, exp_tx.pop_front()});
                tx_bytes++;
                tx_busy = 1'b1;
                busy_left = $urandom_range(2, 6);
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                tx_busy = 1'b1;
                busy_left = $urandom_range(1, 3);
            end
        end
    end

    // Completion monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (exp_res.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    chk("result", result, exp_res.pop_front());
                    chk("rdy_clr_count", rc_cnt, exp_rc.pop_front());
                    chk("frames_before_done", exp_tx.size(), 0);
                end
                rc_cnt = 0;
            end
            if (rdy_clr) rc_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, base;
        repeat (3) @(negedge clk);
        chk("reset_state", {28'b0, state}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_wr_en", {31'b0, wr_en}, 32'd0);
        chk("reset_rdy_clr", {31'b0, rdy_clr}, 32'd0);
        chk("reset_txdata", {24'b0, txdata}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        clear_plan();
        push4(HR, 8'h00, 8'h2A, 8'h2A);
        run_txn(32'h0000_0261, 32'h0000_0010);

        clear_plan();
        repeat (4) push4(HR, 8'h00, 8'h2A, 8'h2B);
        run_txn(32'h0000_0261, 32'h0000_0010);

        clear_plan();
        repeat (4) end_att();
        run_txn(32'h0000_0261, 32'h0000_0010);

        clear_plan();
        push_b(8'h13);
        push4(HR, 8'h00, 8'h2A, 8'h2A);
        run_txn(32'h0000_0261, 32'h0000_0010);

        clear_plan();
        push4(HR, 8'h00, 8'h2A, 8'h2B);
        push4(HR, 8'h01, 8'h07, 8'h08);
        run_txn(32'h1234_0261, 32'hABCD_EF10);

        // Reset while collecting the data byte
        push_frames(8'h3C, 8'h11, 8'h22, 1);
        base = tx_bytes;
        d0 = ndone;
        pulse_start(32'h0000_113C, 32'h0000_0022);
        wait_tx(base + 5);
        send_byte(HR);
        send_byte(8'h11);
        chk("reached_wait_data", {28'b0, state}, 32'd5);
        last_st = 8'h11;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_state", {28'b0, state}, 32'd0);
        chk("midreset_wr_en", {31'b0, wr_en}, 32'd0);
        chk("midreset_rdy_clr", {31'b0, rdy_clr}, 32'd0);
        chk("midreset_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midreset_result", result, 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_reset", ndone, d0);

        clear_plan();
        push4(HR, 8'h5A, 8'h03, 8'h5D);
        run_txn(32'h0000_0704, 32'h0000_0009);

        for (int t = 0; t < 30; t++) begin
            clear_plan();
            for (int k = 0; k <= MR; k++) begin
                int kind;
                logic [7:0] s1, d1, sm, g;
                kind = $urandom_range(0, 5);
                if (kind == 5) begin
                    end_att();
                    continue;
                end
                s1 = 8'($urandom);
                d1 = 8'($urandom);
                sm = s1 + d1;
                if (kind >= 3) sm = sm + 8'($urandom_range(1, 255));
                if (kind == 2) begin
                    repeat ($urandom_range(1, 2)) begin
                        g = 8'($urandom);
                        if (g == HR) g = 8'h00;
                        push_b(g);
                    end
                end
                push4(HR, s1, d1, sm);
                if (kind < 3) break;
            end
            run_txn($urandom, $urandom);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_res.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
